int_clk_divider: RTL and testbench

- Integer clock divider that consumes the division ratio produced by the prescale-to-ratio mapper and generates the derived (RX-side) clock from the reference clock.
- Supports even and odd ratios.
- Ratio changes are applied glitch-free at period boundaries.
- Falls back to a bypass path (output = input clock) when disabled or when the ratio is 0/1.
- Sits in the clock-generation section beside the mapper, one instance per derived clock.

---
 rtl/int_clk_divider_pkg.sv | 10 +
 rtl/int_clk_divider_clk_mux.sv | 9 +
 rtl/int_clk_divider.sv | 68 ++++++
 tb/tb_int_clk_divider.sv | 130 +++++++++++++
 4 files changed

// File: rtl/int_clk_divider_pkg.sv
// int_clk_divider_pkg: shared clock-generation constants and the divider state type.
package int_clk_divider_pkg;
    localparam int DEF_RATIO_WD  = 8;
    localparam int MIN_DIV_RATIO = 2;
    localparam int DIV_1         = 1;
    localparam int DIV_2         = 2;
    localparam int DIV_4         = 4;
    localparam int DIV_8         = 8;
    typedef enum logic {BYPASS = 1'b0, DIVIDE = 1'b1} div_state_e;
endpackage

// File: rtl/int_clk_divider_clk_mux.sv
// clk_mux_cell: 2:1 clock mux, kept as its own module so a library clock-mux cell can replace it.
module clk_mux_cell (
    input  logic IN_0,
    input  logic IN_1,
    input  logic SEL,
    output logic OUT
);
    assign OUT = SEL ? IN_1 : IN_0;
endmodule

// File: rtl/int_clk_divider.sv
// int_clk_divider: integer clock divider (even/odd N) with ratio updates at period boundaries
// and a bypass path (output = CLK) when disabled or N < 2.
module int_clk_divider
    import int_clk_divider_pkg::*;
#(
    parameter int RATIO_WD = DEF_RATIO_WD
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                i_clk_en,
    input  logic [RATIO_WD-1:0] i_div_ratio,
    output logic                o_div_clk,
    output logic                o_active
);
    div_state_e          state_q, state_n;
    logic [RATIO_WD-1:0] cnt, cnt_n, ratio_q, ratio_n;
    logic                div_q, div_n, valid, wrap;

    assign valid = i_clk_en && (i_div_ratio >= RATIO_WD'(MIN_DIV_RATIO));
    assign wrap  = (cnt == ratio_q - RATIO_WD'(1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= BYPASS;
            cnt     <= '0;
            ratio_q <= '0;
            div_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt     <= cnt_n;
            ratio_q <= ratio_n;
            div_q   <= div_n;
        end
    end

    // On the wrap cycle the low/high split is taken from the ratio being latched for the new period.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt;
        ratio_n = ratio_q;
        div_n   = div_q;
        if (state_q == BYPASS) begin
            if (valid) begin
                state_n = DIVIDE;
                ratio_n = i_div_ratio;
                cnt_n   = '0;
                div_n   = 1'b0;
            end
        end else if (!valid) begin
            state_n = BYPASS;
            cnt_n   = '0;
            div_n   = 1'b0;
        end else begin
            cnt_n   = wrap ? '0 : cnt + RATIO_WD'(1);
            ratio_n = wrap ? i_div_ratio : ratio_q;
            div_n   = (cnt_n >= (ratio_n >> 1));
        end
    end

    assign o_active = (state_q == DIVIDE);

    clk_mux_cell u_clk_mux (
        .IN_0(CLK),
        .IN_1(div_q),
        .SEL (o_active),
        .OUT (o_div_clk)
    );
endmodule

// File: tb/tb_int_clk_divider.sv
// tb_int_clk_divider: directed + random stimulus checked against a per-period waveform model.
module tb_int_clk_divider;
    import int_clk_divider_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       i_clk_en = 1'b0;
    logic [7:0] i_div_ratio = '0;
    logic       o_div_clk, o_active;
    int         tests = 0;
    int         fails = 0;

    bit act = 1'b0;
    bit exp_div = 1'b0;
    bit q[$];

    int_clk_divider #(.RATIO_WD(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .i_clk_en   (i_clk_en),
        .i_div_ratio(i_div_ratio),
        .o_div_clk  (o_div_clk),
        .o_active   (o_active)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // A period of ratio n is n/2 low cycles followed by the remaining high cycles;
    // a new period is queued only once the previous one is fully consumed.
    task automatic model_edge();
        int n;
        n = int'(i_div_ratio);
        if (!RST || !i_clk_en || n < MIN_DIV_RATIO) begin
            act = 1'b0;
            q.delete();
        end else begin
            if (!act || q.size() == 0) begin
                q.delete();
                for (int i = 0; i < n; i++) q.push_back(i >= n / 2);
            end
            act = 1'b1;
            exp_div = q.pop_front();
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            model_edge();
            #1;
            check("active_hi", o_active, act);
            check("clk_hi", o_div_clk, act ? exp_div : 1'b1);
            @(negedge CLK);
            #1;
            check("active_lo", o_active, act);
            check("clk_lo", o_div_clk, act ? exp_div : 1'b0);
        end
    endtask

    initial begin
        #3;
        check("rst_active", o_active, 1'b0);
        check("rst_clk_lo", o_div_clk, 1'b0);
        step(2);
        RST = 1'b1;
        i_clk_en = 1'b1;
        i_div_ratio = 8'(DIV_4);
        step(45);
        i_div_ratio = 8'd5;
        step(32);
        i_div_ratio = 8'd3;
        step(20);
        i_div_ratio = 8'(DIV_8);
        step(14);
        i_div_ratio = 8'(DIV_2);
        step(12);
        i_div_ratio = 8'(DIV_1);
        step(6);
        i_div_ratio = 8'd0;
        step(4);
        i_clk_en = 1'b0;
        i_div_ratio = 8'(DIV_4);
        step(4);
        i_div_ratio = 8'(DIV_1);
        repeat (3) begin
            i_clk_en = ~i_clk_en;
            step(2);
        end
        i_clk_en = 1'b1;
        i_div_ratio = 8'(DIV_4);
        step(12);
        i_clk_en = 1'b0;
        step(2);
        i_clk_en = 1'b1;
        i_div_ratio = 8'd6;
        step(5);
        check("pre_rst_high", o_div_clk, 1'b1);
        RST = 1'b0;
        #1;
        check("async_rst_active", o_active, 1'b0);
        check("async_rst_clk", o_div_clk, 1'b0);
        act = 1'b0;
        q.delete();
        step(3);
        RST = 1'b1;
        step(14);
        i_div_ratio = 8'd255;
        step(530);
        repeat (300) begin
            case ($urandom_range(0, 9))
                0: i_div_ratio = 8'd0;
                1: i_div_ratio = 8'd1;
                2: i_div_ratio = 8'd255;
                default: i_div_ratio = 8'($urandom_range(2, 12));
            endcase
            i_clk_en = ($urandom_range(0, 7) != 0);
            step($urandom_range(1, 12));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
